if_prefetch_buffer: RTL

IF_PREFETCH_BUFFER -- requirements
Module: if_prefetch_buffer

---
 rtl/if_prefetch_buffer_pkg.sv | 15 +
 rtl/if_prefetch_buffer_if.sv | 14 +
 rtl/if_prefetch_buffer_ifq_fifo.sv | 62 ++++++
 rtl/if_prefetch_buffer.sv | 106 ++++++++++
 4 files changed

// File: rtl/if_prefetch_buffer_pkg.sv
// Shared CPU constants and types for the instruction-fetch prefetch buffer.
package if_prefetch_buffer_pkg;

    localparam int          XLEN          = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0033;
    localparam logic [31:0] RESET_PC_DEF  = 32'h1000_0000;
    // Wide enough for responses still owed by memory across many redirects
    localparam int          DISCARD_W     = 16;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_prefetch_buffer_if.sv
// Instruction memory request/response bus between the fetch unit and memory.
interface if_prefetch_buffer_if;
    import if_prefetch_buffer_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/if_prefetch_buffer_ifq_fifo.sv
// Circular instruction queue: DEPTH entries of {instr, pc}, with synchronous clear.
module ifq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + (AW+1)'(1);
            else if (pop && !push) count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only observed after it was written
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch buffer: credit-limited fetch, in-order response queue, redirect flush.
// state | meaning
// BOOT  | single idle cycle after reset release, no requests
// RUN   | fetching; left only by reset
module if_prefetch_buffer
    import if_prefetch_buffer_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                  clk,
    input  logic                  n_rst,
    if_prefetch_buffer_if.master  imem,
    input  logic                  redirect,
    input  logic [XLEN-1:0]       redirect_pc,
    input  logic                  core_ready,
    output logic                  instr_valid,
    output logic [XLEN-1:0]       instr,
    output logic [XLEN-1:0]       instr_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e         state_q, state_d;
    logic [XLEN-1:0]      fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]      resp_pc_q, resp_pc_d;
    logic [CW-1:0]        outstanding_q, outstanding_d;
    logic [DISCARD_W-1:0] discard_q, discard_d;

    logic            rv_ok, fire, credit_ok;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [63:0]     head_data;
    logic [XLEN-1:0] target_pc;
    logic            unused_pc_lsb;

    assign target_pc     = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_lsb = ^redirect_pc[1:0];

    // A response is legitimate only if some request is still owed
    assign rv_ok     = imem.rvalid && ((discard_q != '0) || (outstanding_q != '0));
    assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(DEPTH);
    assign imem.req  = (state_q == RUN) && !redirect && credit_ok;
    assign imem.addr = fetch_pc_q;
    assign fire      = imem.req && imem.gnt;
    assign fifo_push = !redirect && rv_ok && (discard_q == '0);
    assign fifo_pop  = instr_valid && core_ready && !redirect;

    always_comb begin
        state_d       = RUN;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redirect) begin
            fetch_pc_d    = target_pc;
            resp_pc_d     = target_pc;
            outstanding_d = '0;
            discard_d     = discard_q + DISCARD_W'(outstanding_q) - DISCARD_W'(rv_ok);
        end else begin
            if (fire)      fetch_pc_d = fetch_pc_q + 32'd4;
            if (fifo_push) resp_pc_d  = resp_pc_q + 32'd4;
            outstanding_d = outstanding_q + CW'(fire) - CW'(fifo_push);
            if (rv_ok && (discard_q != '0)) discard_d = discard_q - DISCARD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    ifq_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_ifq_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (fifo_push),
        .push_data ({imem.rdata, resp_pc_q}),
        .pop       (fifo_pop),
        .clear     (redirect),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = instr_valid ? head_data[63:32] : NOP_INSTR;
    assign instr_pc    = instr_valid ? head_data[31:0]  : '0;

    a_no_push_full: assert property (@(posedge clk) disable iff (!n_rst) !(fifo_push && fifo_full));
    a_rvalid_owed:  assert property (@(posedge clk) disable iff (!n_rst)
                                     imem.rvalid |-> ((discard_q != '0) || (outstanding_q != '0)));
    a_addr_align:   assert property (@(posedge clk) disable iff (!n_rst) imem.addr[1:0] == 2'b00);

endmodule
